uart_tx_cfg: RTL
================

UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 SHALL provide parameter CLK_FREQ, default 50_000_000, meaning clock frequency in Hz.
REQ-002 SHALL provide parameter BAUD_RATE, default 9600, meaning line bit rate in bit/s.
REQ-003 SHALL provide parameter DATA_BITS, default 8, meaning data bits per frame; legal range 5..8.
REQ-004 SHALL provide parameter STOP_BITS, default 1, meaning stop bits per frame; legal values 1, 2.
REQ-005 SHALL provide parameter PARITY_ODD, default 0, meaning 0 = even parity, 1 = odd parity; used only with UART_TX_PARITY_EN.
REQ-006 SHALL have port clk, input, 1, system clock, rising edge.
REQ-007 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-008 SHALL have port s_valid_i, input, 1, byte offered.
REQ-009 SHALL have port s_data_i, input, 8, byte to send; bits above DATA_BITS-1 ignored.
REQ-010 SHALL have port s_ready_o, output, 1, holding register empty; byte accepted when s_valid_i and s_ready_o are high at a rising edge.
REQ-011 SHALL have port tx_o, output, 1, serial line, idle high.
REQ-012 SHALL have port busy_o, output, 1, high while FSM not IDLE or holding register full.
REQ-013 SHALL have port tx_done_o, output, 1, one-clock pulse at frame completion.

Function
REQ-014 SHALL use bit period T = CLK_FREQ/BAUD_RATE clocks (integer division); counter wraps at T-1; T < 2 is illegal.
REQ-015 SHALL contain a one-entry holding register plus a separate shift register (double buffering); s_ready_o = !hold_full, registered.
REQ-016 SHALL implement FSM states IDLE, START, DATA, PARITY (macro only), STOP.
REQ-017 IDLE with hold_full: SHALL move the byte to the shift register, clear hold_full, enter START; tx_o low two clocks after the accept edge.
REQ-018 START SHALL drive tx_o low for T clocks, then enter DATA.
REQ-019 DATA SHALL send DATA_BITS bits, LSB first, T clocks each, then enter PARITY (macro) or STOP.
REQ-020 STOP SHALL drive tx_o high for STOP_BITS*T clocks.
REQ-021 SHALL assert tx_done_o for exactly one clock, in the clock following the last stop-bit clock.
REQ-022 In that clock, if hold_full, SHALL load the next byte and drive the start bit (no idle gap); otherwise SHALL return to IDLE with tx_o high.
REQ-023 A byte accepted during a frame SHALL wait in the holding register; no byte is dropped or duplicated while s_valid_i is held across s_ready_o low.
REQ-024 tx_o SHALL be driven from a flop (glitch-free).

Reset
REQ-025 rst_n low SHALL immediately force tx_o=1, s_ready_o=1, busy_o=0, tx_done_o=0, FSM=IDLE, counters=0, hold_full=0.
REQ-026 Reset mid-frame SHALL abandon the frame and discard the held byte, with no tx_done_o pulse.

Configuration
REQ-027 With macro UART_TX_PARITY_EN defined, SHALL insert one parity bit of T clocks after the data bits: XOR of the sent data bits, inverted when PARITY_ODD=1.
REQ-028 Without UART_TX_PARITY_EN, SHALL have no PARITY state or logic and ignore PARITY_ODD.

Verification (CLK_FREQ=1_000_000, BAUD_RATE=100_000, T=10; accept edge = cycle 0)
REQ-029 0xA5, 8N1 -> tx_o low cycles 2-11, bits 1,0,1,0,0,1,0,1 for 10 clocks each over cycles 12-91, high 92-101, tx_done_o at cycle 102 only, busy_o low from 102.
REQ-030 0x00 then 0xFF, s_valid_i held -> second accept at cycle 2 (s_ready_o high again), second start bit begins cycle 102 coincident with tx_done_o, no idle clock.
REQ-031 UART_TX_PARITY_EN, PARITY_ODD=0, 0x07 -> parity bit 1 on cycles 92-101, stop 102-111, tx_done_o at 112; PARITY_ODD=1 -> parity 0.
REQ-032 DATA_BITS=7, STOP_BITS=2, 0x80 -> seven 0 data bits (bit 7 ignored), tx_o high 20 clocks, tx_done_o at cycle 102.
REQ-033 rst_n low at cycle 50 of a 0xA5 frame with a second byte held -> tx_o=1 same cycle, no tx_done_o, held byte lost; after release, 0x3C transmits per REQ-029 timing.

Source files
------------

// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - double-buffered UART transmitter with configurable framing
// Optional parity bit is compiled in with `define UART_TX_PARITY_EN.

module uart_tx_cfg #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s_valid_i,
    input  logic [7:0] s_data_i,
    output logic       s_ready_o,
    output logic       tx_o,
    output logic       busy_o,
    output logic       tx_done_o
);

    localparam int               BIT_T     = CLK_FREQ / BAUD_RATE;
    localparam int               CNT_W     = (BIT_T > 2) ? $clog2(BIT_T) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BIT_T - 1);
    localparam logic [7:0]       DATA_MASK = 8'((1 << DATA_BITS) - 1);
    localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

    if (BIT_T < 2) begin : g_bad_bit_period
        $error("uart_tx_cfg: CLK_FREQ/BAUD_RATE must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
        $error("uart_tx_cfg: DATA_BITS must be 5..8");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity_odd
        $error("uart_tx_cfg: PARITY_ODD must be 0 or 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       hold_q;
    logic             hold_full_q, hold_full_d;
    logic [7:0]       shift_q;
    logic             done_q;
    logic             load;
    logic             frame_end;
    logic             line_d;
    logic             accept;
    logic             bit_end;

    assign accept  = s_valid_i && s_ready_o;
    assign bit_end = (cnt_q == CNT_LAST);

    // Next-state: every non-idle state runs the bit counter; idx walks data or stop bits.
    always_comb begin
        state_d   = state_q;
        cnt_d     = bit_end ? '0 : cnt_q + 1'b1;
        idx_d     = idx_q;
        load      = 1'b0;
        frame_end = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (hold_full_q) begin
                    load    = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    idx_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (idx_q == DATA_LAST) begin
                        idx_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    idx_d   = '0;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    if (idx_q == STOP_LAST) begin
                        frame_end = 1'b1;
                        idx_d     = '0;
                        // A waiting byte starts immediately so back-to-back frames have no gap.
                        if (hold_full_q) begin
                            load    = 1'b1;
                            state_d = S_START;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                idx_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // accept and load never coincide: accept needs s_ready_o, which mirrors !hold_full_q.
    always_comb begin
        hold_full_d = hold_full_q;
        if (accept) begin
            hold_full_d = 1'b1;
        end else if (load) begin
            hold_full_d = 1'b0;
        end
    end

    always_comb begin
        line_d = 1'b1;
        case (state_q)
            S_IDLE:   line_d = 1'b1;
            S_START:  line_d = 1'b0;
            S_DATA:   line_d = shift_q[idx_q];
`ifdef UART_TX_PARITY_EN
            S_PARITY: line_d = (^(shift_q & DATA_MASK)) ^ 1'(PARITY_ODD);
`endif
            S_STOP:   line_d = 1'b1;
            default:  line_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            s_ready_o   <= 1'b1;
            tx_o        <= 1'b1;
            busy_o      <= 1'b0;
            done_q      <= 1'b0;
            tx_done_o   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            hold_full_q <= hold_full_d;
            s_ready_o   <= !hold_full_d;
            if (accept) begin
                hold_q <= s_data_i & DATA_MASK;
            end
            if (load) begin
                shift_q <= hold_q;
            end
            // Line and done pulse trail the FSM by one clock so tx_o comes straight from a flop.
            tx_o      <= line_d;
            busy_o    <= (state_q != S_IDLE) || hold_full_q;
            done_q    <= frame_end;
            tx_done_o <= done_q;
        end
    end

endmodule
